dac_sign_restore: RTL and testbench

- Return path for the rectified ADC stream: takes an unsigned 16-bit magnitude plus a separate sign bit and rebuilds a signed sample.
- Saturates the sample, applies a soft-start/soft-stop gain ramp, and formats it as a 14-bit word for the Red Pitaya DAC.
- Sits between the feedback/processing logic and the DAC output register in the 125 MHz ADC/DAC clock domain.

---
 rtl/dac_sign_restore_pkg.sv | 38 +++
 rtl/dac_sign_restore_if.sv | 20 ++
 rtl/dac_sign_restore_soft_ramp_ctrl.sv | 90 +++++++++
 rtl/dac_sign_restore.sv | 80 ++++++++
 tb/tb_dac_sign_restore.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_sign_restore_pkg.sv
// Shared types, widths and helpers for the DAC sign-restore return path.
package dac_sign_restore_pkg;

  localparam int unsigned DAC_W    = 14;
  localparam int unsigned SAMPLE_W = 16;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } ramp_state_e;

  // Rebuild a signed sample from magnitude + sign and clamp to 16-bit signed.
  function automatic logic signed [SAMPLE_W-1:0] sat_signed(input logic [SAMPLE_W-1:0] mag,
                                                            input logic sign);
    logic signed [SAMPLE_W:0] v;
    v = sign ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    if (v > 17'sd32767) begin
      return SAT_MAX;
    end else if (v < -17'sd32768) begin
      return SAT_MIN;
    end
    return v[SAMPLE_W-1:0];
  endfunction

  // Truncate to 14 bits and optionally apply the Red Pitaya offset-inverted format.
  function automatic logic [DAC_W-1:0] dac_fmt(input logic signed [SAMPLE_W-1:0] s,
                                               input logic inv);
    logic [DAC_W-1:0] s14;
    s14 = DAC_W'(s >>> 2);
    return inv ? {s14[DAC_W-1], ~s14[DAC_W-2:0]} : s14;
  endfunction

endpackage

// File: rtl/dac_sign_restore_if.sv
// Sample stream in (magnitude/sign/valid) and formatted DAC word out.
interface dac_sign_restore_if;
  import dac_sign_restore_pkg::*;

  logic [SAMPLE_W-1:0] mag_i;
  logic                sign_i;
  logic                valid_i;
  logic [DAC_W-1:0]    dac_data_o;
  logic                valid_o;

  modport slave (
    input  mag_i, sign_i, valid_i,
    output dac_data_o, valid_o
  );

  modport master (
    output mag_i, sign_i, valid_i,
    input  dac_data_o, valid_o
  );
endinterface

// File: rtl/dac_sign_restore_soft_ramp_ctrl.sv
// Soft-start/soft-stop gain ramp: FSM plus step prescaler.
module soft_ramp_ctrl
  import dac_sign_restore_pkg::*;
#(
  parameter int unsigned RAMP_W   = 8,
  parameter int unsigned RAMP_DIV = 125
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          enable_i,
  output logic [RAMP_W:0] gain_o,
  output ramp_state_e   state_o,
  output logic          busy_o
);

  localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(RAMP_DIV - 1);
  localparam logic [RAMP_W:0] G_FULL     = {1'b1, {RAMP_W{1'b0}}};

  ramp_state_e     state_q, state_d;
  logic [RAMP_W:0] gain_q, gain_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            busy_q, busy_d;
  logic            step;

  // Next state, gain and prescaler; a direction change pre-empts a same-cycle step.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    presc_d = presc_q;
    step    = (presc_q == PRESC_LAST);
    unique case (state_q)
      ST_IDLE: begin
        gain_d  = '0;
        presc_d = '0;
        if (enable_i) state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (!enable_i) begin
          state_d = ST_RAMP_DOWN;
          presc_d = '0;
        end else if (step) begin
          presc_d = '0;
          if (gain_q != G_FULL) gain_d = gain_q + 1'b1;
          if (gain_d == G_FULL) state_d = ST_RUN;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_RUN: begin
        gain_d  = G_FULL;
        presc_d = '0;
        if (!enable_i) state_d = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        if (enable_i) begin
          state_d = ST_RAMP_UP;
          presc_d = '0;
        end else if (step) begin
          presc_d = '0;
          if (gain_q != '0) gain_d = gain_q - 1'b1;
          if (gain_d == '0) state_d = ST_IDLE;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
    endcase
    busy_d = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
  end

  // Ramp state registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      gain_q  <= '0;
      presc_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      presc_q <= presc_d;
      busy_q  <= busy_d;
    end
  end

  assign gain_o  = gain_q;
  assign state_o = state_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/dac_sign_restore.sv
// Sign restore, saturation, soft gain ramp and DAC formatting (3-stage pipeline).
module dac_sign_restore
  import dac_sign_restore_pkg::*;
#(
  parameter int unsigned RAMP_W   = 8,
  parameter int unsigned RAMP_DIV = 125,
  parameter bit          DAC_INV  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    enable_i,
  dac_sign_restore_if.slave       bus,
  output logic [1:0]              ramp_state_o,
  output logic                    busy_o
);

  localparam int unsigned PROD_W = SAMPLE_W + RAMP_W + 2;
  localparam logic [DAC_W-1:0] DAC_ZERO = DAC_INV ? {1'b0, {(DAC_W-1){1'b1}}} : '0;

  logic [RAMP_W:0] gain;
  ramp_state_e     ramp_state;

  logic signed [SAMPLE_W-1:0] s1_q, s1_d;
  logic signed [SAMPLE_W-1:0] s2_q, s2_d;
  logic [DAC_W-1:0]           dac_q, dac_d;
  logic                       v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [PROD_W-1:0]   prod;

  soft_ramp_ctrl #(
    .RAMP_W   (RAMP_W),
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .enable_i (enable_i),
    .gain_o   (gain),
    .state_o  (ramp_state),
    .busy_o   (busy_o)
  );

  // Stage data advances only behind a valid bit; otherwise every stage holds.
  always_comb begin
    s1_d = s1_q;
    v1_d = bus.valid_i;
    if (bus.valid_i) s1_d = sat_signed(bus.mag_i, bus.sign_i);

    prod = s1_q * $signed({1'b0, gain});
    s2_d = s2_q;
    v2_d = v1_q;
    if (v1_q) s2_d = SAMPLE_W'(prod >>> RAMP_W);

    dac_d = dac_q;
    v3_d  = v2_q;
    if (v2_q) dac_d = dac_fmt(s2_q, DAC_INV);
  end

  // Pipeline registers; reset leaves the DAC at its zero code.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_q  <= '0;
      s2_q  <= '0;
      dac_q <= DAC_ZERO;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      dac_q <= dac_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
    end
  end

  assign bus.dac_data_o = dac_q;
  assign bus.valid_o    = v3_q;
  assign ramp_state_o   = ramp_state;

endmodule

// File: tb/tb_dac_sign_restore.sv
// Bench for dac_sign_restore: two parameterisations against a cycle-level reference model.
module tb_dac_sign_restore;

  logic       clk;
  logic       rstn_a, rstn_b, en_a, en_b;
  logic [1:0] st_a, st_b;
  logic       busy_a, busy_b;

  dac_sign_restore_if if_a ();
  dac_sign_restore_if if_b ();

  dac_sign_restore #(.RAMP_W(2), .RAMP_DIV(1), .DAC_INV(1'b0)) dut_a (
    .clk_i(clk), .rstn_i(rstn_a), .enable_i(en_a), .bus(if_a),
    .ramp_state_o(st_a), .busy_o(busy_a)
  );

  dac_sign_restore #(.RAMP_W(2), .RAMP_DIV(3), .DAC_INV(1'b1)) dut_b (
    .clk_i(clk), .rstn_i(rstn_b), .enable_i(en_b), .bus(if_b),
    .ramp_state_o(st_b), .busy_o(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int P_W[2]   = '{2, 2};
  int P_DIV[2] = '{1, 3};
  int P_INV[2] = '{0, 1};

  // Reference model state (0: dut_a, 1: dut_b); states 0 IDLE,1 UP,2 RUN,3 DOWN
  int m_g[2], m_st[2], m_pc[2], m_s1[2], m_s2[2], m_out[2];
  bit m_v1[2], m_v2[2], m_v3[2];

  function automatic int sat16(int mag, bit sgn);
    int v;
    v = sgn ? -mag : mag;
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int floor_div(int a, int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int fmt(int s, int inv);
    int c;
    c = floor_div(s, 4) & 16383;
    if (inv != 0) c = c ^ 8191;
    return c;
  endfunction

  task automatic model_reset(input int i);
    m_g[i] = 0; m_st[i] = 0; m_pc[i] = 0;
    m_s1[i] = 0; m_s2[i] = 0;
    m_v1[i] = 0; m_v2[i] = 0; m_v3[i] = 0;
    m_out[i] = (P_INV[i] != 0) ? 'h1FFF : 0;
  endtask

  task automatic model_step(input int i, input bit rn, input bit en, input int mag,
                            input bit sgn, input bit vin);
    int  full;
    bit  step;
    if (!rn) begin
      model_reset(i);
      return;
    end
    if (m_v2[i]) m_out[i] = fmt(m_s2[i], P_INV[i]);
    m_v3[i] = m_v2[i];
    if (m_v1[i]) m_s2[i] = floor_div(m_s1[i] * m_g[i], 1 << P_W[i]);
    m_v2[i] = m_v1[i];
    if (vin) m_s1[i] = sat16(mag, sgn);
    m_v1[i] = vin;
    full = 1 << P_W[i];
    step = (m_pc[i] == P_DIV[i] - 1);
    case (m_st[i])
      0: if (en) begin m_st[i] = 1; m_pc[i] = 0; end
      1: begin
        if (!en) begin m_st[i] = 3; m_pc[i] = 0; end
        else if (step) begin
          m_pc[i] = 0;
          if (m_g[i] < full) m_g[i] = m_g[i] + 1;
          if (m_g[i] == full) m_st[i] = 2;
        end else m_pc[i] = m_pc[i] + 1;
      end
      2: if (!en) begin m_st[i] = 3; m_pc[i] = 0; end
      default: begin
        if (en) begin m_st[i] = 1; m_pc[i] = 0; end
        else if (step) begin
          m_pc[i] = 0;
          if (m_g[i] > 0) m_g[i] = m_g[i] - 1;
          if (m_g[i] == 0) m_st[i] = 0;
        end else m_pc[i] = m_pc[i] + 1;
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.dac",   32'(if_a.dac_data_o),     m_out[0]);
    chk("a.valid", 32'(if_a.valid_o),        32'(m_v3[0]));
    chk("a.state", 32'(st_a),                m_st[0]);
    chk("a.busy",  32'(busy_a),              32'(m_st[0] == 1 || m_st[0] == 3));
    chk("a.gain",  32'(dut_a.u_ramp.gain_o), m_g[0]);
    chk("b.dac",   32'(if_b.dac_data_o),     m_out[1]);
    chk("b.valid", 32'(if_b.valid_o),        32'(m_v3[1]));
    chk("b.state", 32'(st_b),                m_st[1]);
    chk("b.busy",  32'(busy_b),              32'(m_st[1] == 1 || m_st[1] == 3));
    chk("b.gain",  32'(dut_b.u_ramp.gain_o), m_g[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, rstn_a, en_a, int'(if_a.mag_i), if_a.sign_i, if_a.valid_i);
    model_step(1, rstn_b, en_b, int'(if_b.mag_i), if_b.sign_i, if_b.valid_i);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input int i, input int mag, input bit sgn, input bit vld);
    if (i == 0) begin
      if_a.mag_i = 16'(mag); if_a.sign_i = sgn; if_a.valid_i = vld;
    end else begin
      if_b.mag_i = 16'(mag); if_b.sign_i = sgn; if_b.valid_i = vld;
    end
  endtask

  task automatic drive_rand(input int i);
    int sel, mag;
    sel = $urandom_range(0, 7);
    case (sel)
      0: mag = 0;
      1: mag = 'h8000;
      2: mag = 'hFFFF;
      3: mag = 'h7FFF;
      default: mag = $urandom_range(0, 65535);
    endcase
    drive(i, mag, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
  endtask

  // One qualified sample into both DUTs, then confirm the 3-cycle latency and result.
  task automatic send_one(input string tag, input int mag, input bit sgn,
                          input int exp_a, input int exp_b);
    drive(0, mag, sgn, 1'b0); drive(1, mag, sgn, 1'b0);
    repeat (4) tick();
    drive(0, mag, sgn, 1'b1); drive(1, mag, sgn, 1'b1);
    tick();
    drive(0, mag, sgn, 1'b0); drive(1, mag, sgn, 1'b0);
    chk({tag, ".lat1"}, 32'(if_a.valid_o), 0);
    tick();
    chk({tag, ".lat2"}, 32'(if_a.valid_o), 0);
    tick();
    chk({tag, ".vo_a"}, 32'(if_a.valid_o), 1);
    chk({tag, ".vo_b"}, 32'(if_b.valid_o), 1);
    chk({tag, ".dac_a"}, 32'(if_a.dac_data_o), exp_a);
    chk({tag, ".dac_b"}, 32'(if_b.dac_data_o), exp_b);
    tick();
    chk({tag, ".vo_off"}, 32'(if_a.valid_o), 0);
    chk({tag, ".hold_a"}, 32'(if_a.dac_data_o), exp_a);
  endtask

  int gexp[8] = '{0, 1, 2, 3, 4, 4, 4, 4};
  int sexp[8] = '{1, 1, 1, 1, 2, 2, 2, 2};
  int dexp[8] = '{0, 0, 0, 62, 125, 187, 250, 250};

  initial begin
    bit found;
    rstn_a = 1'b0; rstn_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    drive(0, 0, 1'b0, 1'b0); drive(1, 0, 1'b0, 1'b0);
    model_reset(0); model_reset(1);
    repeat (2) tick();
    chk("rst.b.dac",   32'(if_b.dac_data_o), 'h1FFF);
    chk("rst.b.valid", 32'(if_b.valid_o), 0);
    chk("rst.b.state", 32'(st_b), 0);
    chk("rst.a.dac",   32'(if_a.dac_data_o), 0);

    // Streaming with enable low: gain stays zero, output stays at the zero code.
    rstn_a = 1'b1; rstn_b = 1'b1;
    drive(0, 1000, 1'b0, 1'b1); drive(1, 1000, 1'b0, 1'b1);
    repeat (6) tick();
    chk("idle.b.dac",   32'(if_b.dac_data_o), 'h1FFF);
    chk("idle.b.valid", 32'(if_b.valid_o), 1);
    chk("idle.a.dac",   32'(if_a.dac_data_o), 0);

    // Ramp up with one step per cycle on dut_a.
    en_a = 1'b1; en_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("up.a.gain",  32'(dut_a.u_ramp.gain_o), gexp[k]);
      chk("up.a.state", 32'(st_a), sexp[k]);
      chk("up.a.dac",   32'(if_a.dac_data_o), dexp[k]);
    end
    repeat (14) tick();
    chk("up.b.run", 32'(st_b), 2);

    // Random samples with both DUTs at full gain.
    for (int k = 0; k < 40; k++) begin
      drive_rand(0); drive_rand(1);
      tick();
    end

    send_one("fmt.pos", 'h0100, 1'b0, 'h0040, 'h1FBF);
    send_one("fmt.neg", 'h0100, 1'b1, 'h3FC0, 'h203F);
    send_one("sat.p8000", 'h8000, 1'b0, 'h1FFF, 'h0000);
    send_one("sat.n8000", 'h8000, 1'b1, 'h2000, 'h3FFF);
    send_one("sat.pFFFF", 'hFFFF, 1'b0, 'h1FFF, 'h0000);
    send_one("sat.nzero", 0, 1'b1, 'h0000, 'h1FFF);

    // Reversal on dut_b (3 cycles per step).
    rstn_b = 1'b0;
    tick();
    rstn_b = 1'b1; en_b = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      tick();
      if (m_g[1] == 2 && m_st[1] == 1) found = 1'b1;
    end
    chk("rev.reach_g2", 32'(found), 1);
    en_b = 1'b0;
    tick();
    chk("rev.down.state", 32'(st_b), 3);
    chk("rev.down.gain",  32'(dut_b.u_ramp.gain_o), 2);
    repeat (2) tick();
    chk("rev.down.hold", 32'(dut_b.u_ramp.gain_o), 2);
    tick();
    chk("rev.down.g1", 32'(dut_b.u_ramp.gain_o), 1);
    en_b = 1'b1;
    tick();
    chk("rev.up.state", 32'(st_b), 1);
    chk("rev.up.gain",  32'(dut_b.u_ramp.gain_o), 1);
    repeat (2) tick();
    chk("rev.up.hold", 32'(dut_b.u_ramp.gain_o), 1);
    tick();
    chk("rev.up.g2", 32'(dut_b.u_ramp.gain_o), 2);
    en_b = 1'b0;
    repeat (7) tick();
    chk("rev.idle.state", 32'(st_b), 0);
    chk("rev.idle.gain",  32'(dut_b.u_ramp.gain_o), 0);
    chk("rev.idle.busy",  32'(busy_b), 0);

    // Random enable toggling and random samples.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 7) == 0) en_a = ~en_a;
      if ($urandom_range(0, 5) == 0) en_b = ~en_b;
      drive_rand(0); drive_rand(1);
      tick();
    end

    // Asynchronous reset between edges while dut_a is ramping at G=3.
    rstn_a = 1'b0; en_a = 1'b0;
    tick();
    rstn_a = 1'b1; en_a = 1'b1;
    drive(0, 1000, 1'b0, 1'b1);
    repeat (4) tick();
    chk("arst.pre.gain",  32'(dut_a.u_ramp.gain_o), 3);
    chk("arst.pre.state", 32'(st_a), 1);
    chk("arst.pre.dac",   32'(if_a.dac_data_o), 62);
    #2 rstn_a = 1'b0;
    #1;
    model_reset(0);
    chk("arst.gain",  32'(dut_a.u_ramp.gain_o), 0);
    chk("arst.state", 32'(st_a), 0);
    chk("arst.busy",  32'(busy_a), 0);
    chk("arst.dac",   32'(if_a.dac_data_o), 0);
    chk("arst.valid", 32'(if_a.valid_o), 0);
    tick();
    rstn_a = 1'b1;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
